// File: rtl/tmds_gearbox.sv
// tmds_gearbox: multi-lane word-to-chunk gearbox for the TMDS transmit path.
// Loads one WORD_WIDTH-bit symbol per lane every PHASES clocks and shifts it
// out LSB-first as OUT_WIDTH-bit chunks, all in the chunk-rate clock domain.
// WORD_WIDTH must be an integer multiple of OUT_WIDTH.
//
// Ports:
//   clk              chunk-rate clock
//   reset            synchronous active-high reset
//   s_data           one word per lane, lane c at [c*WORD_WIDTH +: WORD_WIDTH]
//   s_valid          s_data holds a word for all lanes
//   s_ready          word is taken this cycle (combinational, load cycle only)
//   pattern_en       load PATTERN_WORD instead of s_data at the next load
//   dout             registered chunk per lane, lane c at [c*OUT_WIDTH +: OUT_WIDTH]
//   word_start       dout carries chunk 0 of a word
//   underflow        sticky flag, set whenever IDLE_WORD is loaded
//   clear_underflow  clears underflow (an idle load in the same cycle wins)
module tmds_gearbox #(
    parameter int unsigned            CHANNELS     = 3,
    parameter int unsigned            WORD_WIDTH   = 10,
    parameter int unsigned            OUT_WIDTH    = 2,
    parameter logic [WORD_WIDTH-1:0]  IDLE_WORD    = 10'b1101010100,
    parameter logic [WORD_WIDTH-1:0]  PATTERN_WORD = 10'b0000011111,
    parameter logic [CHANNELS-1:0]    INVERT_MASK  = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CHANNELS*WORD_WIDTH-1:0]  s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic                            pattern_en,
    output logic [CHANNELS*OUT_WIDTH-1:0]   dout,
    output logic                            word_start,
    output logic                            underflow,
    input  logic                            clear_underflow
);

    localparam int unsigned PHASES = WORD_WIDTH / OUT_WIDTH;
    localparam int unsigned PH_W   = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(PHASES - 1);

    // Reset value of dout: zero data, shown through each lane's inversion.
    function automatic logic [CHANNELS*OUT_WIDTH-1:0] invert_expand();
        logic [CHANNELS*OUT_WIDTH-1:0] v;
        v = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            v[c*OUT_WIDTH +: OUT_WIDTH] = {OUT_WIDTH{INVERT_MASK[c]}};
        end
        return v;
    endfunction

    localparam logic [CHANNELS*OUT_WIDTH-1:0] DOUT_RST = invert_expand();

    logic [PH_W-1:0]                          phase_q, phase_d;
    logic [CHANNELS-1:0][WORD_WIDTH-1:0]      shreg_q, shreg_d;
    logic [CHANNELS*OUT_WIDTH-1:0]            dout_q, dout_d;
    logic                                     word_start_q, word_start_d;
    logic                                     underflow_q, underflow_d;
    logic                                     load_cycle;
    logic                                     idle_load;

    assign load_cycle = (phase_q == LAST_PHASE);
    assign idle_load  = load_cycle && !pattern_en && !s_valid;
    assign s_ready    = load_cycle && !pattern_en && !reset;

    // Next-state: phase counter, per-lane shift/load, output chunk, flags.
    always_comb begin
        phase_d      = phase_q + PH_W'(1);
        shreg_d      = shreg_q;
        dout_d       = dout_q;
        word_start_d = (phase_q == '0);
        underflow_d  = underflow_q;

        if (load_cycle) begin
            phase_d = '0;
        end

        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (!load_cycle) begin
                shreg_d[c] = shreg_q[c] >> OUT_WIDTH;
            end else if (pattern_en) begin
                shreg_d[c] = PATTERN_WORD;
            end else if (s_valid) begin
                shreg_d[c] = s_data[c*WORD_WIDTH +: WORD_WIDTH];
            end else begin
                shreg_d[c] = IDLE_WORD;
            end
            dout_d[c*OUT_WIDTH +: OUT_WIDTH] =
                shreg_q[c][OUT_WIDTH-1:0] ^ {OUT_WIDTH{INVERT_MASK[c]}};
        end

        // Set has priority over clear.
        if (idle_load) begin
            underflow_d = 1'b1;
        end else if (clear_underflow) begin
            underflow_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q      <= '0;
            shreg_q      <= {CHANNELS{IDLE_WORD}};
            dout_q       <= DOUT_RST;
            word_start_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            word_start_q <= word_start_d;
            underflow_q  <= underflow_d;
        end
    end

    assign dout       = dout_q;
    assign word_start = word_start_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_tmds_gearbox.sv
// Self-checking bench for tmds_gearbox: constant vector tables, hand-written
// corner sequences and random traffic against a chunk-queue reference model.
// A second instance with OUT_WIDTH == WORD_WIDTH covers the single-phase case.
module tb_tmds_gearbox;

    localparam int unsigned PH = 5;
    localparam logic [2:0]  INV  = 3'b010;
    localparam logic [9:0]  IDLE = 10'b1101010100;
    localparam logic [9:0]  PAT  = 10'b0000011111;
    localparam logic [5:0]  INV6 = 6'b001100;

    logic        clk = 1'b0;
    logic        reset, s_valid, pattern_en, clear_underflow;
    logic [29:0] s_data;
    logic        s_ready, word_start, underflow;
    logic [5:0]  dout;

    logic        s_valid1;
    logic [9:0]  s_data1;
    logic        s_ready1, word_start1, underflow1;
    logic [9:0]  dout1;

    always #5 clk = ~clk;

    tmds_gearbox #(
        .CHANNELS(3), .WORD_WIDTH(10), .OUT_WIDTH(2),
        .IDLE_WORD(IDLE), .PATTERN_WORD(PAT), .INVERT_MASK(INV)
    ) u_dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .pattern_en(pattern_en), .dout(dout),
        .word_start(word_start), .underflow(underflow),
        .clear_underflow(clear_underflow)
    );

    tmds_gearbox #(
        .CHANNELS(1), .WORD_WIDTH(10), .OUT_WIDTH(10),
        .IDLE_WORD(IDLE), .PATTERN_WORD(PAT), .INVERT_MASK(1'b0)
    ) u_p1 (
        .clk(clk), .reset(reset), .s_data(s_data1), .s_valid(s_valid1),
        .s_ready(s_ready1), .pattern_en(pattern_en), .dout(dout1),
        .word_start(word_start1), .underflow(underflow1),
        .clear_underflow(clear_underflow)
    );

    int tests = 0;
    int fails = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Each lane's output is a stream of chunks; a queue holds the chunks still
    // to be emitted (all lanes side by side), topped up with a whole word
    // every PH cycles counted from reset release.
    typedef struct packed {
        logic [5:0] raw;
        logic       first;
    } chunk_t;

    chunk_t     mq[$];
    int         m_t    = 0;
    bit         m_init = 1'b0;
    logic [5:0] m_dout;
    logic       m_ws, m_uf;
    logic [9:0] m1_word, m1_dout;
    logic       m1_ws, m1_uf;

    function automatic logic [29:0] all_lanes(logic [9:0] x);
        return {x, x, x};
    endfunction

    function automatic void push_word(logic [29:0] w);
        chunk_t ch;
        for (int k = 0; k < PH; k++) begin
            for (int c = 0; c < 3; c++) begin
                ch.raw[c*2 +: 2] = w[c*10 + k*2 +: 2];
            end
            ch.first = (k == 0);
            mq.push_back(ch);
        end
    endfunction

    function automatic logic model_ready();
        return !reset && !pattern_en && ((m_t % PH) == PH - 1);
    endfunction

    function automatic void model_edge();
        chunk_t h;
        if (reset) begin
            mq.delete();
            push_word(all_lanes(IDLE));
            m_dout = INV6;
            m_ws   = 1'b0;
            m_uf   = 1'b0;
            m_t    = 0;
            m1_word = IDLE;
            m1_dout = '0;
            m1_ws   = 1'b0;
            m1_uf   = 1'b0;
            m_init  = 1'b1;
        end else begin
            h      = mq.pop_front();
            m_dout = h.raw ^ INV6;
            m_ws   = h.first;
            if ((m_t % PH) == PH - 1) begin
                if (pattern_en)   push_word(all_lanes(PAT));
                else if (s_valid) push_word(s_data);
                else              push_word(all_lanes(IDLE));
            end
            if ((m_t % PH) == PH - 1 && !pattern_en && !s_valid) m_uf = 1'b1;
            else if (clear_underflow)                             m_uf = 1'b0;
            m_t++;
            // Single-phase instance: every cycle loads, output lags by one word.
            m1_dout = m1_word;
            m1_ws   = 1'b1;
            m1_word = pattern_en ? PAT : (s_valid1 ? s_data1 : IDLE);
            if (!pattern_en && !s_valid1) m1_uf = 1'b1;
            else if (clear_underflow)     m1_uf = 1'b0;
        end
    endfunction

    // One clock: ready check before the edge, output checks #1 after it.
    task automatic do_cycle();
        if (m_init) begin
            chk("s_ready", 32'(s_ready), 32'(model_ready()));
            chk("s_ready_p1", 32'(s_ready1), 32'(!reset && !pattern_en));
        end
        @(posedge clk);
        model_edge();
        #1;
        chk("dout", 32'(dout), 32'(m_dout));
        chk("word_start", 32'(word_start), 32'(m_ws));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("dout_p1", 32'(dout1), 32'(m1_dout));
        chk("word_start_p1", 32'(word_start1), 32'(m1_ws));
        chk("underflow_p1", 32'(underflow1), 32'(m1_uf));
    endtask

    task automatic settle();
        s_valid1 = 1'($urandom);
        s_data1  = 10'($urandom);
        #1;
    endtask

    task automatic step();
        settle();
        do_cycle();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst, vld, pat, clr;
        logic [9:0] word;
        logic       exp_rdy;
        logic [5:0] exp_dout;
        logic       exp_ws, exp_uf;
    } vec_t;

    vec_t       vt[$];
    logic [5:0] idle6[5];

    function automatic void addv(logic rst, logic vld, logic clr, logic [9:0] word,
                                 logic rdy, logic [5:0] d, logic ws, logic uf);
        vec_t v;
        v.rst = rst; v.vld = vld; v.pat = 1'b0; v.clr = clr; v.word = word;
        v.exp_rdy = rdy; v.exp_dout = d; v.exp_ws = ws; v.exp_uf = uf;
        vt.push_back(v);
    endfunction

    logic [29:0] w;
    logic [5:0]  exp6;

    initial begin
        reset = 1'b1; s_valid = 1'b0; pattern_en = 1'b0; clear_underflow = 1'b0;
        s_data = '0; s_valid1 = 1'b0; s_data1 = '0;

        // IDLE_WORD chunks per lane {l2,l1,l0}, lane 1 inverted.
        idle6[0] = 6'b001100; idle6[1] = 6'b011001; idle6[2] = 6'b011001;
        idle6[3] = 6'b011001; idle6[4] = 6'b110011;

        // Reset then idle: repeating IDLE chunks, underflow from first load.
        addv(1, 0, 0, '0, 0, INV6, 0, 0);
        for (int i = 0; i < 12; i++)
            addv(0, 0, 0, '0, (i % 5) == 4, idle6[i % 5], (i % 5) == 0, i >= 4);
        // Reset then stream 3FF, 000, 2AA, 155 with clear held high.
        addv(1, 0, 0, '0, 0, INV6, 0, 0);
        for (int i = 0; i < 25; i++) begin
            if (i < 5)       exp6 = idle6[i];
            else if (i < 10) exp6 = 6'b110011;
            else if (i < 15) exp6 = 6'b001100;
            else if (i < 20) exp6 = 6'b100110;
            else             exp6 = 6'b011001;
            addv(0, i < 20, 1,
                 (i < 5) ? 10'h3FF : (i < 10) ? 10'h000 : (i < 15) ? 10'h2AA : 10'h155,
                 (i % 5) == 4, exp6, (i % 5) == 0, i == 24);
        end

        foreach (vt[n]) begin
            reset = vt[n].rst; s_valid = vt[n].vld; pattern_en = vt[n].pat;
            clear_underflow = vt[n].clr; s_data = all_lanes(vt[n].word);
            settle();
            chk("vec_ready", 32'(s_ready), 32'(vt[n].exp_rdy));
            do_cycle();
            chk("vec_dout", 32'(dout), 32'(vt[n].exp_dout));
            chk("vec_word_start", 32'(word_start), 32'(vt[n].exp_ws));
            chk("vec_underflow", 32'(underflow), 32'(vt[n].exp_uf));
        end
        clear_underflow = 1'b0;

        // Word presented at phase 2 is held until the load cycle.
        reset = 1'b1; s_valid = 1'b0; step();
        reset = 1'b0; step(); step();
        w = 30'($urandom); s_data = w; s_valid = 1'b1;
        for (int p = 2; p <= 4; p++) begin
            settle();
            chk("held_ready", 32'(s_ready), 32'(p == 4));
            do_cycle();
        end
        s_valid = 1'b0; s_data = '0;
        step();
        chk("held_chunk0", 32'(dout), 32'({w[21:20], ~w[11:10], w[1:0]}));
        chk("held_ws", 32'(word_start), 32'd1);

        // pattern_en raised mid-word: current word finishes, then pattern.
        reset = 1'b1; step();
        reset = 1'b0; s_valid = 1'b1; w = 30'($urandom); s_data = w;
        for (int p = 0; p < 5; p++) step();
        s_valid = 1'b0;
        step(); step();
        pattern_en = 1'b1; s_valid = 1'b1;
        for (int p = 7; p <= 9; p++) begin
            settle();
            chk("pat_ready", 32'(s_ready), 32'd0);
            do_cycle();
        end
        chk("pat_last_old", 32'(dout[1:0]), 32'(w[9:8]));
        for (int k = 0; k < 5; k++) begin
            step();
            exp6[1:0] = (k < 2) ? 2'b11 : (k == 2) ? 2'b01 : 2'b00;
            chk("pat_chunk", 32'(dout[1:0]), 32'(exp6[1:0]));
        end
        chk("pat_no_underflow", 32'(underflow), 32'd0);
        pattern_en = 1'b0; s_valid = 1'b0;

        // Reset mid-word at phase 3 discards the word and clears underflow.
        reset = 1'b1; step();
        reset = 1'b0;
        for (int p = 0; p < 9; p++) step();
        s_valid = 1'b1; s_data = 30'($urandom); step();
        s_valid = 1'b0;
        for (int p = 10; p < 13; p++) step();
        chk("pre_reset_underflow", 32'(underflow), 32'd1);
        reset = 1'b1; step();
        chk("midreset_underflow", 32'(underflow), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_reset_dout", 32'(dout), 32'(idle6[k]));
            chk("post_reset_ws", 32'(word_start), 32'(k == 0));
        end

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            reset           = ($urandom_range(0, 59) == 0);
            s_valid         = ($urandom_range(0, 3) != 0);
            s_data          = 30'($urandom);
            clear_underflow = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) pattern_en = !pattern_en;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
